result_trace_buffer: RTL and testbench
======================================

// Module: result_trace_buffer
// PURPOSE
//   Downstream capture stage for the single-cycle processor's 32-bit Result bus.
//   Samples Result each qualified cycle into a synchronous FIFO, optionally
//   suppressing consecutive duplicate values. A slower consumer (UART/debug
//   port, testbench monitor) drains it through a valid/ready handshake.
//   Overflow is counted, never back-pressured: the processor cannot stall.
// PARAMETERS
//   DATA_W   32   width of captured Result word
//   DEPTH    16   FIFO entries; power of 2, >= 2
//   DEDUP    1    1: drop a value equal to the last accepted value; 0: capture all
//   CNT_W    16   width of drop counter (saturating)
// PORTS
//   clk          in   1                 system clock
//   reset        in   1                 synchronous, active-high reset
//   result_in    in   DATA_W            processor Result bus
//   sample_en    in   1                 qualify capture this cycle (tie 1 for every cycle)
//   out_data     out  DATA_W            head-of-FIFO word
//   out_valid    out  1                 out_data is valid
//   out_ready    in   1                 consumer accepts the head word
//   level        out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//   drop_count   out  CNT_W             values lost to full FIFO, saturating
//   overflow     out  1                 sticky: set on first drop, cleared by reset only
// BEHAVIOUR
//   Reset: rd/wr pointers 0, level 0, out_valid 0, drop_count 0, overflow 0,
//     last-accepted register 0 with has_last 0. out_data undefined while out_valid 0.
//   Offer: offer = sample_en & (!DEDUP | !has_last | result_in != last_acc).
//   Pop: pop = out_valid & out_ready; head advances on that clock edge.
//   Push: push = offer & (level < DEPTH | pop). Push while full with a
//     simultaneous pop is accepted; level unchanged.
//   On push: mem[wr_ptr] <= result_in; wr_ptr++; last_acc <= result_in; has_last <= 1.
//   Drop: offer & !push -> drop_count++ (holds at 2^CNT_W-1), overflow <= 1.
//     Dropped value does NOT update last_acc, so an identical next value is retried.
//   Dedup-rejected value (not offered) is neither stored nor counted.
//   Level: +1 on push only, -1 on pop only, unchanged on both or neither.
//   Latency: word pushed at edge N appears on out_valid/out_data after edge N
//     (no combinational fall-through from result_in to out_data).
//   Empty: out_valid 0; out_ready ignored; pop never occurs.
//   Pointers: log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0; full/empty from level.
//   out_data = mem[rd_ptr]; stable while out_valid & !out_ready.
//   Reset mid-operation: all contents discarded in the same cycle; out_valid
//     low on the cycle after reset asserts; no stale word is re-presented.
// STRUCTURE
//   Shared package: none needed; DEPTH power-of-2 check as an elaboration-time
//     assertion in this module.
//   Sub-module: sync_fifo (DATA_W, DEPTH) holding mem, pointers, level, with
//     push/pop/full/empty; this module adds the dedup filter, drop counter and
//     overflow flag around it. Instantiated next to processor at the top level,
//     result_in wired to processor.Result.
// TESTING
//   1 Reset, sample_en=0 -> out_valid 0, level 0, drop_count 0, overflow 0.
//   2 DEDUP=1, push 5,5,7,7,5 with out_ready=0 -> level 3; drain yields 5,7,5.
//   3 DEPTH=16, out_ready=0, 20 distinct values 1..20 -> level 16, drain 1..16,
//     drop_count 4, overflow 1.
//   4 Full FIFO, same cycle push 99 and out_ready=1 -> level stays 16,
//     99 is the last word drained, drop_count unchanged.
//   5 Full FIFO, offer 42 (dropped), then pop one, offer 42 again -> 42 accepted
//     (last_acc not updated by drop).
//   6 Reset asserted with level 8 mid-drain -> next cycle out_valid 0, level 0;
//     subsequent push 3 emerges as first word.

Source files
------------

// File: rtl/result_trace_buffer_pkg.sv
// Shared helpers for the Result-bus trace buffer.
package result_trace_buffer_pkg;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/result_trace_buffer_if.sv
// Drain-side valid/ready handshake of the trace buffer.
interface result_trace_buffer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/result_trace_buffer_sync_fifo.sv
// Synchronous FIFO: registered storage, free-running pointers, level-based full/empty.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by level_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign empty   = (level_q == '0);
  assign full    = (level_q == DEPTH_L);
  assign level   = level_q;
endmodule

// File: rtl/result_trace_buffer.sv
// Captures the processor Result bus into a FIFO with optional duplicate
// suppression; overflow is counted and flagged, never back-pressured.
module result_trace_buffer
  import result_trace_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int DEDUP  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      result_in,
  input  logic                   sample_en,
  result_trace_buffer_if.master  drain,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow
);
  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("result_trace_buffer: DEPTH must be a power of two and >= 2");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] last_acc_q, last_acc_d;
  logic              has_last_q, has_last_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;

  logic              offer, push, pop, full, empty;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    offer        = sample_en &&
                   ((DEDUP == 0) || !has_last_q || (result_in != last_acc_q));
    pop          = !empty && drain.out_ready;
    push         = offer && (!full || pop);
    last_acc_d   = last_acc_q;
    has_last_d   = has_last_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (push) begin
      last_acc_d = result_in;
      has_last_d = 1'b1;
    end else if (offer) begin
      // A dropped value leaves last_acc alone so a repeat of it is retried.
      drop_count_d = sat_inc(drop_count_q);
      overflow_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_acc_q   <= '0;
      has_last_q   <= 1'b0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      last_acc_q   <= last_acc_d;
      has_last_q   <= has_last_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (result_in),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign drain.out_data  = rd_data;
  assign drain.out_valid = !empty;
  assign drop_count      = drop_count_q;
  assign overflow        = overflow_q;
endmodule

// File: tb/tb_result_trace_buffer.sv
// Bench for result_trace_buffer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_result_trace_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] result_in;
  logic              sample_en;
  logic [4:0]        level;
  logic [CNT_W-1:0]  drop_count;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_last;
  bit                m_has;
  int                m_drop;
  bit                m_ovf;

  result_trace_buffer_if #(.DATA_W(DATA_W)) drain_if ();

  result_trace_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DEDUP  (1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .result_in  (result_in),
    .sample_en  (sample_en),
    .drain      (drain_if),
    .level      (level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the reference model, return 1 ns after the edge.
  task automatic cycle(input bit rst, input logic [DATA_W-1:0] val,
                       input bit en, input bit rdy);
    bit pop, offer, push;
    reset              = rst;
    result_in          = val;
    sample_en          = en;
    drain_if.out_ready = rdy;
    pop   = (mq.size() > 0) && rdy;
    offer = en && !(m_has && (val == m_last));
    push  = offer && ((mq.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_last = '0;
      m_has  = 1'b0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(val);
        m_last = val;
        m_has  = 1'b1;
      end else if (offer) begin
        if (m_drop < (1 << CNT_W) - 1) m_drop++;
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd9, 1'b0, 1'b0);
    checks++; if (drain_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", drain_if.out_valid); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_dedup();
    int vals[5]  = '{5, 5, 7, 7, 5};
    int exp_d[3] = '{5, 7, 5};
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    foreach (vals[i]) cycle(1'b0, vals[i], 1'b1, 1'b0);
    checks++; if (level !== 5'd3) begin failures++; $display("FAIL dedup_level got=%0d exp=3", level); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (drain_if.out_valid !== 1'b1 || drain_if.out_data !== DATA_W'(exp_d[i])) begin
        failures++; $display("FAIL dedup_drain[%0d] got=%0d valid=%0b exp=%0d", i, drain_if.out_data, drain_if.out_valid, exp_d[i]);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
    end
    checks++; if (drain_if.out_valid !== 1'b0) begin failures++; $display("FAIL dedup_empty got=%0b exp=0", drain_if.out_valid); end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    for (int v = 1; v <= 20; v++) cycle(1'b0, DATA_W'(v), 1'b1, 1'b0);
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", level); end
    checks++; if (drop_count !== 16'd4) begin failures++; $display("FAIL ovf_drop_count got=%0d exp=4", drop_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    for (int v = 1; v <= 16; v++) begin
      checks++;
      if (drain_if.out_valid !== 1'b1 || drain_if.out_data !== DATA_W'(v)) begin
        failures++; $display("FAIL ovf_drain got=%0d valid=%0b exp=%0d", drain_if.out_data, drain_if.out_valid, v);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    int expv;
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, DATA_W'(100 + i), 1'b1, 1'b0);
    cycle(1'b0, 32'd99, 1'b1, 1'b1);
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL fullpp_level got=%0d exp=16", level); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL fullpp_drop got=%0d exp=0", drop_count); end
    for (int i = 0; i < 16; i++) begin
      expv = (i < 15) ? 101 + i : 99;
      checks++;
      if (drain_if.out_valid !== 1'b1 || drain_if.out_data !== DATA_W'(expv)) begin
        failures++; $display("FAIL fullpp_drain[%0d] got=%0d exp=%0d", i, drain_if.out_data, expv);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_retry_after_drop();
    logic [DATA_W-1:0] lastw;
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, DATA_W'(200 + i), 1'b1, 1'b0);
    cycle(1'b0, 32'd42, 1'b1, 1'b0);
    checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL retry_drop got=%0d exp=1", drop_count); end
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (level !== 5'd15) begin failures++; $display("FAIL retry_pop_level got=%0d exp=15", level); end
    cycle(1'b0, 32'd42, 1'b1, 1'b0);
    checks++; if (level !== 5'd16 || drop_count !== 16'd1) begin failures++; $display("FAIL retry_accept level=%0d drop=%0d exp level=16 drop=1", level, drop_count); end
    lastw = '0;
    for (int i = 0; i < 16; i++) begin
      lastw = drain_if.out_data;
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
    end
    checks++; if (lastw !== 32'd42) begin failures++; $display("FAIL retry_last_word got=%0d exp=42", lastw); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, DATA_W'(300 + i), 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (level !== 5'd8) begin failures++; $display("FAIL rstmid_pre_level got=%0d exp=8", level); end
    cycle(1'b1, 32'd77, 1'b1, 1'b1);
    checks++; if (drain_if.out_valid !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL rstmid_clear valid=%0b level=%0d exp valid=0 level=0", drain_if.out_valid, level); end
    cycle(1'b0, 32'd3, 1'b1, 1'b0);
    checks++; if (drain_if.out_valid !== 1'b1 || drain_if.out_data !== 32'd3 || level !== 5'd1) begin
      failures++; $display("FAIL rstmid_first got=%0d valid=%0b level=%0d exp=3", drain_if.out_data, drain_if.out_valid, level);
    end
  endtask

  task automatic test_random();
    bit rdy;
    cycle(1'b1, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      rdy = ((i % 120) < 70) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      cycle(1'b0, DATA_W'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), rdy);
      checks++;
      if (level !== 5'(mq.size())) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, mq.size()); end
      checks++;
      if (drain_if.out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", i, drain_if.out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++;
        if (drain_if.out_data !== mq[0]) begin failures++; $display("FAIL rand_data cyc=%0d got=%0d exp=%0d", i, drain_if.out_data, mq[0]); end
      end
      checks++;
      if (drop_count !== CNT_W'(m_drop) || overflow !== m_ovf) begin
        failures++; $display("FAIL rand_drop cyc=%0d got=%0d/%0b exp=%0d/%0b", i, drop_count, overflow, m_drop, m_ovf);
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    result_in          = '0;
    sample_en          = 1'b0;
    drain_if.out_ready = 1'b0;
    test_reset();
    test_dedup();
    test_overflow();
    test_full_push_pop();
    test_retry_after_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
